pipe_hazard_ctrl: RTL

- Hazard and sequencing controller for the 5-stage IF/ID/EX/MEM/WB integer pipeline.
- Tracks destination registers of in-flight instructions and drives stall, bubble, flush and operand-forward selects, so back-to-back dependent ALU ops execute correctly.
- Sequences a multi-cycle MUL op that occupies EX.
- Sits beside the datapath; observes the decode-stage instruction fields only.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/pipe_scoreboard.sv | 53 +++++
 rtl/pipe_hazard_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared opcode constants, forward-select and MUL FSM encodings for the hazard controller.
package pipe_pkg;

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_SUB = 6'b000001;
    localparam logic [5:0] OP_AND = 6'b000010;
    localparam logic [5:0] OP_MUL = 6'b000011;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10,
        FWD_WB    = 2'b11
    } fwd_sel_e;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_e;

    function automatic logic writes_rd(input logic [5:0] opcode);
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_MUL: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Three-slot {valid, dst} shadow of EX/MEM/WB with per-slot match flags for two source indices.
// Bit 0 of each match vector is EX (youngest), bit 1 MEM, bit 2 WB.
module pipe_scoreboard #(
    parameter int RB = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hold,
    input  logic          kill,
    input  logic          in_valid,
    input  logic [RB-1:0] in_dst,
    input  logic [RB-1:0] rs,
    input  logic [RB-1:0] rt,
    output logic [2:0]    match_rs,
    output logic [2:0]    match_rt
);

    logic          ex_vld, mem_vld, wb_vld;
    logic [RB-1:0] ex_dst, mem_dst, wb_dst;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_vld  <= 1'b0;
            mem_vld <= 1'b0;
            wb_vld  <= 1'b0;
            ex_dst  <= '0;
            mem_dst <= '0;
            wb_dst  <= '0;
        end else begin
            // A held EX keeps its producer; MEM sees a bubble while it waits.
            if (kill) begin
                ex_vld <= 1'b0;
            end else if (!hold) begin
                ex_vld <= in_valid;
                ex_dst <= in_dst;
            end
            mem_vld <= hold ? 1'b0 : ex_vld;
            mem_dst <= ex_dst;
            wb_vld  <= mem_vld;
            wb_dst  <= mem_dst;
        end
    end

    always_comb begin
        match_rs[0] = ex_vld  && (ex_dst  == rs) && (rs != '0);
        match_rs[1] = mem_vld && (mem_dst == rs) && (rs != '0);
        match_rs[2] = wb_vld  && (wb_dst  == rs) && (rs != '0);
        match_rt[0] = ex_vld  && (ex_dst  == rt) && (rt != '0);
        match_rt[1] = mem_vld && (mem_dst == rt) && (rt != '0);
        match_rt[2] = wb_vld  && (wb_dst  == rt) && (rt != '0);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard controller: registered forward selects at issue, MUL holds EX for MUL_LAT-1 stalls.
// HAZARD_FWD_EN selects forwarding; without it any RAW match stalls/bubbles until the producer retires.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int RB      = 5,
    parameter int MUL_LAT = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [5:0]    id_opcode,
    input  logic [RB-1:0] id_rs,
    input  logic [RB-1:0] id_rt,
    input  logic [RB-1:0] id_rd,
    input  logic          flush,
    output logic          stall_if,
    output logic          bubble_ex,
    output logic          hold_ex,
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b,
    output logic          ex_busy
);

    mul_state_e state;
    logic [3:0] cnt;
    fwd_sel_e   fwd_a_q, fwd_b_q;
    logic [2:0] match_rs, match_rt;
    logic       busy, data_stall, issue, sb_in_valid;

    assign busy = (state == MUL_BUSY);

`ifdef HAZARD_FWD_EN
    assign data_stall = 1'b0;
`else
    // A busy MUL already freezes ID/EX, so a RAW match must not also inject a bubble.
    assign data_stall = id_valid && !busy && ((|match_rs) || (|match_rt));
`endif

    assign stall_if    = busy || data_stall;
    assign bubble_ex   = flush || data_stall;
    assign hold_ex     = busy && !flush;
    assign issue       = id_valid && !stall_if && !flush;
    assign sb_in_valid = issue && writes_rd(id_opcode) && (id_rd != '0);

    pipe_scoreboard #(.RB(RB)) u_sb (
        .clk      (clk),
        .reset    (reset),
        .hold     (busy),
        .kill     (flush),
        .in_valid (sb_in_valid),
        .in_dst   (id_rd),
        .rs       (id_rs),
        .rt       (id_rt),
        .match_rs (match_rs),
        .match_rt (match_rt)
    );

    function automatic fwd_sel_e pick(input logic [2:0] m);
        if (m[0])      return FWD_EXMEM;
        else if (m[1]) return FWD_MEMWB;
        else if (m[2]) return FWD_WB;
        else           return FWD_NONE;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= MUL_IDLE;
            cnt     <= 4'd0;
            fwd_a_q <= FWD_NONE;
            fwd_b_q <= FWD_NONE;
        end else if (flush) begin
            state   <= MUL_IDLE;
            cnt     <= 4'd0;
            fwd_a_q <= FWD_NONE;
            fwd_b_q <= FWD_NONE;
        end else if (issue) begin
`ifdef HAZARD_FWD_EN
            fwd_a_q <= pick(match_rs);
            fwd_b_q <= pick(match_rt);
`else
            fwd_a_q <= FWD_NONE;
            fwd_b_q <= FWD_NONE;
`endif
            if ((id_opcode == OP_MUL) && (MUL_LAT > 1)) begin
                state <= MUL_BUSY;
                cnt   <= 4'(MUL_LAT - 1);
            end
        end else if (busy) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                state <= MUL_IDLE;
            end
        end
    end

    assign fwd_a   = fwd_a_q;
    assign fwd_b   = fwd_b_q;
    assign ex_busy = busy;

endmodule
